// File: rtl/ofs_plat_hssi_tx_pause_gate.sv
// rtl/ofs_plat_hssi_tx_pause_gate.sv - packet-boundary TX pause gate with quanta timer, XOFF and statistics
module ofs_plat_hssi_tx_pause_gate #(
    parameter int DATA_WIDTH    = 64,
    parameter int QUANTA_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    afu_tvalid,
    output logic                    afu_tready,
    input  logic [DATA_WIDTH-1:0]   afu_tdata,
    input  logic [DATA_WIDTH/8-1:0] afu_tkeep,
    input  logic                    afu_tlast,

    output logic                    hssi_tvalid,
    input  logic                    hssi_tready,
    output logic [DATA_WIDTH-1:0]   hssi_tdata,
    output logic [DATA_WIDTH/8-1:0] hssi_tkeep,
    output logic                    hssi_tlast,

    input  logic                    pause_valid,
    input  logic [15:0]             pause_quanta,
    input  logic                    xoff,

    output logic                    paused,
    output logic [15:0]             pause_req_count,
    output logic [31:0]             blocked_cycles
);

    // Wide enough to hold 0xFFFF quanta times QUANTA_CYCLES without overflow.
    localparam int TW = 16 + $clog2(QUANTA_CYCLES);

    logic          in_pkt;
    logic [TW-1:0] timer;
    logic [15:0]   pause_req_count_r;
    logic [31:0]   blocked_cycles_r;

    logic pause_active;
    logic allow;
    logic accept;

    // allow depends only on registered state and xoff, so the stream path stays glitch-free
    // with respect to the AFU inputs; an open packet is never cut.
    assign pause_active = (timer != '0) | xoff;
    assign allow        = in_pkt | ~pause_active;

    assign hssi_tvalid = afu_tvalid & allow & ~reset;
    assign afu_tready  = hssi_tready & allow & ~reset;
    assign hssi_tdata  = afu_tdata;
    assign hssi_tkeep  = afu_tkeep;
    assign hssi_tlast  = afu_tlast;

    assign accept = hssi_tvalid & hssi_tready;

    assign paused          = pause_active & ~in_pkt & ~reset;
    assign pause_req_count = pause_req_count_r;
    assign blocked_cycles  = blocked_cycles_r;

    // Track whether a packet has started but not yet delivered its last beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_pkt <= 1'b0;
        end else if (accept) begin
            in_pkt <= ~afu_tlast;
        end
    end

    // Pause timer: a new request overwrites; otherwise count down only between packets.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= '0;
        end else if (pause_valid) begin
            timer <= TW'(pause_quanta) * TW'(QUANTA_CYCLES);
        end else if ((timer != '0) && !in_pkt) begin
            timer <= timer - TW'(1);
        end
    end

    // Saturating count of nonzero pause requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            pause_req_count_r <= '0;
        end else if (pause_valid && (pause_quanta != 16'd0) && (pause_req_count_r != 16'hFFFF)) begin
            pause_req_count_r <= pause_req_count_r + 16'd1;
        end
    end

    // Saturating count of cycles where the AFU offered a beat but the gate held it off.
    always_ff @(posedge clk) begin
        if (reset) begin
            blocked_cycles_r <= '0;
        end else if (afu_tvalid && !allow && (blocked_cycles_r != 32'hFFFF_FFFF)) begin
            blocked_cycles_r <= blocked_cycles_r + 32'd1;
        end
    end

endmodule

// File: tb/tb_ofs_plat_hssi_tx_pause_gate.sv
// tb/tb_ofs_plat_hssi_tx_pause_gate.sv - directed self-checking bench for the TX pause gate
module tb_ofs_plat_hssi_tx_pause_gate;

    logic        clk = 1'b0;
    logic        reset;
    logic        afu_tvalid;
    logic        afu_tready;
    logic [63:0] afu_tdata;
    logic [7:0]  afu_tkeep;
    logic        afu_tlast;
    logic        hssi_tvalid;
    logic        hssi_tready;
    logic [63:0] hssi_tdata;
    logic [7:0]  hssi_tkeep;
    logic        hssi_tlast;
    logic        pause_valid;
    logic [15:0] pause_quanta;
    logic        xoff;
    logic        paused;
    logic [15:0] pause_req_count;
    logic [31:0] blocked_cycles;

    int checks   = 0;
    int failures = 0;

    ofs_plat_hssi_tx_pause_gate #(.DATA_WIDTH(64), .QUANTA_CYCLES(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .afu_tvalid      (afu_tvalid),
        .afu_tready      (afu_tready),
        .afu_tdata       (afu_tdata),
        .afu_tkeep       (afu_tkeep),
        .afu_tlast       (afu_tlast),
        .hssi_tvalid     (hssi_tvalid),
        .hssi_tready     (hssi_tready),
        .hssi_tdata      (hssi_tdata),
        .hssi_tkeep      (hssi_tkeep),
        .hssi_tlast      (hssi_tlast),
        .pause_valid     (pause_valid),
        .pause_quanta    (pause_quanta),
        .xoff            (xoff),
        .paused          (paused),
        .pause_req_count (pause_req_count),
        .blocked_cycles  (blocked_cycles)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; afu_tvalid = 1'b1; hssi_tready = 1'b1; xoff = 1'b1;
        pause_valid = 1'b1; pause_quanta = 16'd5;
        afu_tdata = 64'h0; afu_tkeep = 8'hFF; afu_tlast = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (hssi_tvalid !== 1'b0) begin failures++; $display("FAIL reset_hssi_tvalid act=%0b exp=0", hssi_tvalid); end
        checks++; if (afu_tready !== 1'b0) begin failures++; $display("FAIL reset_afu_tready act=%0b exp=0", afu_tready); end
        checks++; if (paused !== 1'b0) begin failures++; $display("FAIL reset_paused act=%0b exp=0", paused); end
        checks++; if (pause_req_count !== 16'd0) begin failures++; $display("FAIL reset_req_count act=%0d exp=0", pause_req_count); end
        checks++; if (blocked_cycles !== 32'd0) begin failures++; $display("FAIL reset_blocked act=%0d exp=0", blocked_cycles); end
        @(negedge clk);
        reset = 1'b0; xoff = 1'b0; pause_valid = 1'b0; afu_tvalid = 1'b0;
        #1;
        checks++; if (paused !== 1'b0) begin failures++; $display("FAIL reset_timer_clear paused=%0b exp=0", paused); end
    endtask

    task automatic test_idle_passthrough();
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < 4; b++) begin
                @(negedge clk);
                afu_tvalid = 1'b1;
                afu_tdata  = 64'h1234_5678_0000_0000 + 64'(p * 16 + b);
                afu_tkeep  = 8'hFF >> b;
                afu_tlast  = (b == 3);
                #1;
                checks++; if ({hssi_tvalid, afu_tready} !== 2'b11) begin failures++; $display("FAIL idle_handshake p%0d b%0d act=%b exp=11", p, b, {hssi_tvalid, afu_tready}); end
                checks++; if (hssi_tdata !== 64'h1234_5678_0000_0000 + 64'(p * 16 + b)) begin failures++; $display("FAIL idle_tdata p%0d b%0d act=%h", p, b, hssi_tdata); end
                checks++; if ({hssi_tkeep, hssi_tlast} !== {8'hFF >> b, b == 3}) begin failures++; $display("FAIL idle_keep_last p%0d b%0d act=%h/%0b", p, b, hssi_tkeep, hssi_tlast); end
                checks++; if (paused !== 1'b0) begin failures++; $display("FAIL idle_paused act=%0b exp=0", paused); end
            end
        end
        @(negedge clk);
        afu_tvalid = 1'b0; afu_tkeep = 8'hFF;
        #1;
        checks++; if (blocked_cycles !== 32'd0) begin failures++; $display("FAIL idle_blocked act=%0d exp=0", blocked_cycles); end
        checks++; if (pause_req_count !== 16'd0) begin failures++; $display("FAIL idle_req_count act=%0d exp=0", pause_req_count); end
    endtask

    task automatic test_quanta_pause();
        @(negedge clk);
        pause_valid = 1'b1; pause_quanta = 16'd2; afu_tvalid = 1'b0;
        #1;
        checks++; if (paused !== 1'b0) begin failures++; $display("FAIL quanta_same_cycle paused=%0b exp=0", paused); end
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            pause_valid = 1'b0; afu_tvalid = 1'b1; afu_tlast = 1'b1; afu_tdata = 64'hBEEF;
            #1;
            checks++; if ({afu_tready, hssi_tvalid, paused} !== 3'b001) begin failures++; $display("FAIL quanta_blocked cycle t+%0d act=%b exp=001", i, {afu_tready, hssi_tvalid, paused}); end
        end
        @(negedge clk);
        #1;
        checks++; if (afu_tready !== 1'b1) begin failures++; $display("FAIL quanta_release act=%0b exp=1", afu_tready); end
        checks++; if (blocked_cycles !== 32'd16) begin failures++; $display("FAIL quanta_blocked_count act=%0d exp=16", blocked_cycles); end
        checks++; if (pause_req_count !== 16'd1) begin failures++; $display("FAIL quanta_req_count act=%0d exp=1", pause_req_count); end
        @(negedge clk);
        afu_tvalid = 1'b0;
    endtask

    task automatic test_mid_packet();
        for (int b = 1; b <= 6; b++) begin
            @(negedge clk);
            afu_tvalid = 1'b1; afu_tlast = (b == 6); afu_tdata = 64'hC0 + 64'(b);
            pause_valid = (b == 2); pause_quanta = 16'd1;
            #1;
            checks++; if (afu_tready !== 1'b1) begin failures++; $display("FAIL midpkt_beat%0d tready act=%0b exp=1", b, afu_tready); end
            if (b == 3) begin
                checks++; if (paused !== 1'b0) begin failures++; $display("FAIL midpkt_paused_in_pkt act=%0b exp=0", paused); end
            end
        end
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            pause_valid = 1'b0; afu_tvalid = 1'b1; afu_tlast = 1'b1;
            #1;
            checks++; if ({afu_tready, paused} !== 2'b01) begin failures++; $display("FAIL midpkt_next_blocked %0d act=%b exp=01", i, {afu_tready, paused}); end
        end
        @(negedge clk);
        #1;
        checks++; if (afu_tready !== 1'b1) begin failures++; $display("FAIL midpkt_release act=%0b exp=1", afu_tready); end
        checks++; if (blocked_cycles !== 32'd24) begin failures++; $display("FAIL midpkt_blocked_count act=%0d exp=24", blocked_cycles); end
        checks++; if (pause_req_count !== 16'd2) begin failures++; $display("FAIL midpkt_req_count act=%0d exp=2", pause_req_count); end
        @(negedge clk);
        afu_tvalid = 1'b0;
    endtask

    task automatic test_overwrite_resume();
        @(negedge clk);
        afu_tvalid = 1'b0; pause_valid = 1'b1; pause_quanta = 16'd10;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            pause_valid = (i == 5); pause_quanta = 16'd0; afu_tvalid = 1'b1; afu_tlast = 1'b1;
            #1;
            checks++; if (afu_tready !== 1'b0) begin failures++; $display("FAIL overwrite_blocked %0d act=%0b exp=0", i, afu_tready); end
        end
        @(negedge clk);
        pause_valid = 1'b0;
        #1;
        checks++; if (afu_tready !== 1'b1) begin failures++; $display("FAIL overwrite_resume act=%0b exp=1", afu_tready); end
        checks++; if (pause_req_count !== 16'd3) begin failures++; $display("FAIL overwrite_req_count act=%0d exp=3", pause_req_count); end
        checks++; if (blocked_cycles !== 32'd29) begin failures++; $display("FAIL overwrite_blocked_count act=%0d exp=29", blocked_cycles); end
        @(negedge clk);
        afu_tvalid = 1'b0;
    endtask

    task automatic test_xoff_backpressure();
        int got;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            xoff = 1'b1; afu_tvalid = 1'b1; afu_tdata = 64'hA0; afu_tlast = 1'b0;
            hssi_tready = i[0]; pause_valid = (i == 5); pause_quanta = 16'd1;
            #1;
            checks++; if ({hssi_tvalid, afu_tready} !== 2'b00) begin failures++; $display("FAIL xoff_blocked %0d act=%b exp=00", i, {hssi_tvalid, afu_tready}); end
            if (i == 0) begin
                checks++; if (paused !== 1'b1) begin failures++; $display("FAIL xoff_same_cycle paused=%0b exp=1", paused); end
            end
        end
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(negedge clk);
            xoff = (got >= 1); pause_valid = 1'b0; afu_tvalid = 1'b1;
            afu_tdata = 64'hA0 + 64'(got); afu_tlast = (got == 3); hssi_tready = cyc[0];
            #1;
            checks++; if (hssi_tvalid !== 1'b1) begin failures++; $display("FAIL xoff_pkt_tvalid cyc%0d act=%0b exp=1", cyc, hssi_tvalid); end
            if (hssi_tvalid && hssi_tready) begin
                checks++; if ({hssi_tdata, hssi_tlast} !== {64'hA0 + 64'(got), got == 3}) begin failures++; $display("FAIL xoff_pkt_beat%0d act=%h/%0b", got, hssi_tdata, hssi_tlast); end
                got++;
            end
        end
        checks++; if (got !== 4) begin failures++; $display("FAIL xoff_pkt_beats act=%0d exp=4", got); end
        @(negedge clk);
        afu_tvalid = 1'b0; hssi_tready = 1'b1;
        #1;
        checks++; if (paused !== 1'b1) begin failures++; $display("FAIL xoff_after_pkt paused=%0b exp=1", paused); end
        @(negedge clk);
        xoff = 1'b0;
        #1;
        checks++; if (paused !== 1'b0) begin failures++; $display("FAIL xoff_release paused=%0b exp=0", paused); end
        checks++; if (blocked_cycles !== 32'd49) begin failures++; $display("FAIL xoff_blocked_count act=%0d exp=49", blocked_cycles); end
    endtask

    task automatic test_reset_mid_packet();
        @(negedge clk);
        afu_tvalid = 1'b1; afu_tlast = 1'b0; afu_tdata = 64'hD1; hssi_tready = 1'b1; xoff = 1'b0;
        #1;
        checks++; if (afu_tready !== 1'b1) begin failures++; $display("FAIL rstpkt_beat1 act=%0b exp=1", afu_tready); end
        @(negedge clk);
        xoff = 1'b1; afu_tdata = 64'hD2;
        #1;
        checks++; if (afu_tready !== 1'b1) begin failures++; $display("FAIL rstpkt_xoff_in_pkt act=%0b exp=1", afu_tready); end
        @(negedge clk);
        reset = 1'b1; afu_tdata = 64'hD3;
        #1;
        checks++; if ({hssi_tvalid, afu_tready, paused} !== 3'b000) begin failures++; $display("FAIL rstpkt_outputs act=%b exp=000", {hssi_tvalid, afu_tready, paused}); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if ({afu_tready, paused} !== 2'b01) begin failures++; $display("FAIL rstpkt_in_pkt_dropped act=%b exp=01", {afu_tready, paused}); end
        checks++; if ({pause_req_count, blocked_cycles} !== 48'd0) begin failures++; $display("FAIL rstpkt_counters act=%0d/%0d exp=0/0", pause_req_count, blocked_cycles); end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        force dut.blocked_cycles_r = 32'hFFFF_FFFE;
        force dut.pause_req_count_r = 16'hFFFE;
        #1;
        release dut.blocked_cycles_r;
        release dut.pause_req_count_r;
        pause_valid = 1'b1; pause_quanta = 16'd3;
        @(negedge clk);
        #1;
        checks++; if (blocked_cycles !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sat_blocked_reach act=%h exp=ffffffff", blocked_cycles); end
        checks++; if (pause_req_count !== 16'hFFFF) begin failures++; $display("FAIL sat_req_reach act=%h exp=ffff", pause_req_count); end
        @(negedge clk);
        pause_valid = 1'b0;
        #1;
        checks++; if (blocked_cycles !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sat_blocked_hold act=%h exp=ffffffff", blocked_cycles); end
        checks++; if (pause_req_count !== 16'hFFFF) begin failures++; $display("FAIL sat_req_hold act=%h exp=ffff", pause_req_count); end
        @(negedge clk);
        xoff = 1'b0; afu_tvalid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; afu_tvalid = 1'b0; afu_tdata = '0; afu_tkeep = 8'hFF; afu_tlast = 1'b0;
        hssi_tready = 1'b1; pause_valid = 1'b0; pause_quanta = 16'd0; xoff = 1'b0;
        test_reset();
        test_idle_passthrough();
        test_quanta_pause();
        test_mid_packet();
        test_overwrite_resume();
        test_xoff_backpressure();
        test_reset_mid_packet();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
